// File: rtl/mem_stage_bus.sv
// ----------------------------------------------------------------------------
// mem_stage_bus
//   Pipelined MEM stage. It accepts one EX/MEM op at a time and runs any
//   load/store on a valid/ready data bus. The result goes out on the wb_*
//   handshake to MEM/WB. Non-memory ops come out one cycle after acceptance.
//   Misaligned or illegal-size accesses fault without touching the bus.
//   A bus that never answers faults after TIMEOUT response cycles.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   in_valid / in_ready         EX/MEM handshake
//   in_mem_op, in_size,         op fields: op (0 none, 1 load, 2 store,
//   in_signed, in_addr,         3 none), size (B/H/W/D), sign-extend flag,
//   in_wdata, in_rd_addr,       effective address, store data, destination
//   in_rd_data                  register and ALU result
//   bus_req_valid/ready         bus request handshake
//   bus_we, bus_addr,           request: direction, word-aligned address,
//   bus_wdata, bus_wrstb        lane-shifted store data and byte strobes
//   bus_rsp_valid, _data, _err  bus response (loads and stores)
//   wb_valid / wb_ready         MEM/WB handshake
//   wb_rd_addr, wb_rd_data,     destination, result, echoed op, fault flag
//   wb_mem_op, wb_fault
// ----------------------------------------------------------------------------
module mem_stage_bus #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int RD_W    = 5,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_mem_op,
   input  logic [1:0]        in_size,
   input  logic              in_signed,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [XLEN-1:0]   in_wdata,
   input  logic [RD_W-1:0]   in_rd_addr,
   input  logic [XLEN-1:0]   in_rd_data,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [XLEN-1:0]   bus_wdata,
   output logic [XLEN/8-1:0] bus_wrstb,
   input  logic              bus_rsp_valid,
   input  logic [XLEN-1:0]   bus_rsp_data,
   input  logic              bus_rsp_err,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [RD_W-1:0]   wb_rd_addr,
   output logic [XLEN-1:0]   wb_rd_data,
   output logic [1:0]        wb_mem_op,
   output logic              wb_fault
);

   localparam int STRB_W = XLEN / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int CNT_W  = $clog2(TIMEOUT + 1);

   localparam logic [1:0] OP_LOAD  = 2'd1;
   localparam logic [1:0] OP_STORE = 2'd2;
   localparam logic [1:0] SZ_B     = 2'd0;
   localparam logic [1:0] SZ_H     = 2'd1;
   localparam logic [1:0] SZ_W     = 2'd2;
   localparam logic [1:0] SZ_D     = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Bit mask covering the low bytes of an access of the given size.
   function automatic logic [XLEN-1:0] size_mask(input logic [1:0] size);
      logic [XLEN-1:0] m;
      case (size)
         SZ_B:    m = XLEN'(8'hFF);
         SZ_H:    m = XLEN'(16'hFFFF);
         SZ_W:    m = XLEN'(32'hFFFF_FFFF);
         default: m = {XLEN{1'b1}};
      endcase
      return m;
   endfunction

   // Byte strobes of an access of the given size at lane offset 0.
   function automatic logic [STRB_W-1:0] size_strb(input logic [1:0] size);
      logic [STRB_W-1:0] s;
      case (size)
         SZ_B:    s = STRB_W'(8'h01);
         SZ_H:    s = STRB_W'(8'h03);
         SZ_W:    s = STRB_W'(8'h0F);
         default: s = {STRB_W{1'b1}};
      endcase
      return s;
   endfunction

   // True when the address is not a multiple of the access size.
   function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
      logic m;
      case (size)
         SZ_B:    m = 1'b0;
         SZ_H:    m = addr_lo[0];
         SZ_W:    m = |addr_lo[1:0];
         default: m = |addr_lo;
      endcase
      return m;
   endfunction

   state_t             state_r;
   state_t             state_next_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [1:0]         size_r;
   logic               signed_r;
   logic [OFF_W-1:0]   off_r;

   logic               bus_req_valid_r;
   logic               bus_we_r;
   logic [ADDR_W-1:0]  bus_addr_r;
   logic [XLEN-1:0]    bus_wdata_r;
   logic [STRB_W-1:0]  bus_wrstb_r;
   logic               wb_valid_r;
   logic [RD_W-1:0]    wb_rd_addr_r;
   logic [XLEN-1:0]    wb_rd_data_r;
   logic [1:0]         wb_mem_op_r;
   logic               wb_fault_r;

   logic               is_mem_s;
   logic               is_store_s;
   logic               bad_s;
   state_t             branch_s;
   logic [OFF_W-1:0]   in_off_s;
   logic               in_ready_s;
   logic               accept_s;
   logic               timeout_s;
   logic [XLEN-1:0]    lane_s;
   logic [XLEN-1:0]    ld_mask_s;
   logic               sign_s;
   logic [XLEN-1:0]    load_ext_s;

   // Decode the incoming op and pick the state it branches to on acceptance.
   always_comb begin
      is_store_s = (in_mem_op == OP_STORE);
      is_mem_s   = (in_mem_op == OP_LOAD) || is_store_s;
      in_off_s   = in_addr[OFF_W-1:0];
      // A doubleword access needs a 64-bit bus.
      bad_s      = is_mem_s && (is_misaligned(in_addr[2:0], in_size) ||
                                ((in_size == SZ_D) && (XLEN < 64)));
      if (is_mem_s && !bad_s) begin
         branch_s = ST_REQ;
      end else begin
         branch_s = ST_DONE;
      end
   end

   // Handshake outputs; in_ready follows wb_ready in DONE so ops can run back to back.
   always_comb begin
      in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && wb_ready);
      accept_s   = in_valid && in_ready_s;
      timeout_s  = (cnt_r == CNT_W'(TIMEOUT - 1));
   end

   // Next-state logic. In RSP a response takes priority over timeout expiry.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_next_s = branch_s;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus_req_ready) begin
               state_next_s = ST_RSP;
            end else begin
               state_next_s = ST_REQ;
            end
         end
         ST_RSP: begin
            if (bus_rsp_valid || timeout_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_RSP;
            end
         end
         ST_DONE: begin
            if (accept_s) begin
               state_next_s = branch_s;
            end else if (wb_ready) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_DONE;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Load lane extraction and sign/zero extension of the bus response.
   always_comb begin
      lane_s    = bus_rsp_data >> {off_r, 3'b000};
      ld_mask_s = size_mask(size_r);
      case (size_r)
         SZ_B:    sign_s = lane_s[7];
         SZ_H:    sign_s = lane_s[15];
         SZ_W:    sign_s = lane_s[31];
         default: sign_s = lane_s[XLEN-1];
      endcase
      if (signed_r && sign_s) begin
         load_ext_s = (lane_s & ld_mask_s) | ~ld_mask_s;
      end else begin
         load_ext_s = lane_s & ld_mask_s;
      end
   end

   // Response-wait counter, cleared whenever RSP is left or not yet entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_RSP) && (state_next_s == ST_RSP)) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= {CNT_W{1'b0}};
      end
   end

   // Capture of op fields, bus request and writeback result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         size_r          <= 2'd0;
         signed_r        <= 1'b0;
         off_r           <= {OFF_W{1'b0}};
         bus_req_valid_r <= 1'b0;
         bus_we_r        <= 1'b0;
         bus_addr_r      <= {ADDR_W{1'b0}};
         bus_wdata_r     <= {XLEN{1'b0}};
         bus_wrstb_r     <= {STRB_W{1'b0}};
         wb_valid_r      <= 1'b0;
         wb_rd_addr_r    <= {RD_W{1'b0}};
         wb_rd_data_r    <= {XLEN{1'b0}};
         wb_mem_op_r     <= 2'd0;
         wb_fault_r      <= 1'b0;
      end else begin
         bus_req_valid_r <= (state_next_s == ST_REQ);
         wb_valid_r      <= (state_next_s == ST_DONE);
         if (accept_s) begin
            size_r       <= in_size;
            signed_r     <= in_signed;
            off_r        <= in_off_s;
            bus_we_r     <= is_store_s;
            bus_addr_r   <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            // Bytes outside the access are zeroed so idle lanes stay quiet.
            bus_wdata_r  <= is_store_s ? ((in_wdata & size_mask(in_size)) << {in_off_s, 3'b000})
                                       : {XLEN{1'b0}};
            bus_wrstb_r  <= is_store_s ? (size_strb(in_size) << in_off_s) : {STRB_W{1'b0}};
            wb_rd_addr_r <= in_rd_addr;
            wb_mem_op_r  <= in_mem_op;
            wb_fault_r   <= bad_s;
            wb_rd_data_r <= is_mem_s ? {XLEN{1'b0}} : in_rd_data;
         end else if (state_r == ST_RSP) begin
            if (bus_rsp_valid) begin
               // A faulted load returns zero; writeback acts on wb_fault.
               wb_fault_r   <= bus_rsp_err;
               wb_rd_data_r <= ((wb_mem_op_r == OP_LOAD) && !bus_rsp_err) ? load_ext_s
                                                                          : {XLEN{1'b0}};
            end else if (timeout_s) begin
               wb_fault_r   <= 1'b1;
               wb_rd_data_r <= {XLEN{1'b0}};
            end
         end
      end
   end

   assign in_ready      = in_ready_s;
   assign bus_req_valid = bus_req_valid_r;
   assign bus_we        = bus_we_r;
   assign bus_addr      = bus_addr_r;
   assign bus_wdata     = bus_wdata_r;
   assign bus_wrstb     = bus_wrstb_r;
   assign wb_valid      = wb_valid_r;
   assign wb_rd_addr    = wb_rd_addr_r;
   assign wb_rd_data    = wb_rd_data_r;
   assign wb_mem_op     = wb_mem_op_r;
   assign wb_fault      = wb_fault_r;

endmodule

// File: tb/tb_mem_stage_bus.sv
module tb_mem_stage_bus;

   localparam int TMO = 4;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_mem_op;
   logic [1:0]  in_size;
   logic        in_signed;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic [4:0]  in_rd_addr;
   logic [31:0] in_rd_data;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wrstb;
   logic        bus_rsp_valid;
   logic [31:0] bus_rsp_data;
   logic        bus_rsp_err;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_rd_data;
   logic [1:0]  wb_mem_op;
   logic        wb_fault;

   int total = 0;
   int bad   = 0;

   mem_stage_bus #(.XLEN(32), .ADDR_W(32), .RD_W(5), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_mem_op(in_mem_op),
      .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wrstb(bus_wrstb), .bus_rsp_valid(bus_rsp_valid),
      .bus_rsp_data(bus_rsp_data), .bus_rsp_err(bus_rsp_err),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_addr(wb_rd_addr),
      .wb_rd_data(wb_rd_data), .wb_mem_op(wb_mem_op), .wb_fault(wb_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      check_val({tag, "_req_valid"}, 64'(bus_req_valid), 64'd0);
      check_val({tag, "_bus_addr"}, 64'(bus_addr), 64'd0);
      check_val({tag, "_bus_we"}, 64'(bus_we), 64'd0);
      check_val({tag, "_bus_wdata"}, 64'(bus_wdata), 64'd0);
      check_val({tag, "_bus_wrstb"}, 64'(bus_wrstb), 64'd0);
      check_val({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
      check_val({tag, "_wb_data"}, 64'(wb_rd_data), 64'd0);
      check_val({tag, "_wb_fault"}, 64'(wb_fault), 64'd0);
      check_val({tag, "_wb_op"}, 64'(wb_mem_op), 64'd0);
   endtask

   // One complete op from acceptance to writeback. Expected values come from the
   // access rules: size in bytes = 2**size, byte offset = addr mod 4.
   task automatic run_op(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic [31:0] rdd,
                         input int req_wait, input int rsp_wait, input logic rsp_err,
                         input logic [31:0] rsp_data, input int wb_wait);
      logic        is_mem, is_load, is_store, fault_pre;
      int          off, nbytes;
      logic [63:0] mask, tmp;
      logic [31:0] lane, ext, e_data;
      logic        e_fault;
      is_load   = (op == 2'd1);
      is_store  = (op == 2'd2);
      is_mem    = is_load || is_store;
      nbytes    = 1 << size;
      off       = int'(addr % 32'd4);
      fault_pre = is_mem && (((addr % nbytes) != 0) || (size == 2'd3));
      mask      = (size == 2'd3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);

      in_valid = 1'b1; in_mem_op = op; in_size = size; in_signed = sgn;
      in_addr = addr; in_wdata = wdata; in_rd_addr = rd; in_rd_data = rdd;
      #1;
      check_val("accept_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_rd_data = $urandom; in_addr = $urandom;

      if (!is_mem) begin
         e_fault = 1'b0; e_data = rdd;
         check_val("none_no_req", 64'(bus_req_valid), 64'd0);
      end else if (fault_pre) begin
         e_fault = 1'b1; e_data = 32'd0;
         check_val("bad_no_req", 64'(bus_req_valid), 64'd0);
      end else begin
         for (int i = 0; i <= req_wait; i++) begin
            check_val("req_valid", 64'(bus_req_valid), 64'd1);
            check_val("req_addr", 64'(bus_addr), 64'(addr & 32'hFFFF_FFFC));
            check_val("req_we", 64'(bus_we), 64'(is_store));
            tmp = is_store ? ((64'(wdata) & mask) << (8 * off)) : 64'd0;
            check_val("req_wdata", 64'(bus_wdata), 64'(tmp[31:0]));
            tmp = is_store ? (((64'd1 << nbytes) - 64'd1) << off) : 64'd0;
            check_val("req_wrstb", 64'(bus_wrstb), 64'(tmp[3:0]));
            check_val("req_wb_idle", 64'(wb_valid), 64'd0);
            bus_req_ready = (i == req_wait);
            // Stray responses while the request is pending must be ignored.
            bus_rsp_valid = 1'($urandom % 2); bus_rsp_err = 1'b1; bus_rsp_data = $urandom;
            @(posedge clk); #1;
         end
         bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
         for (int c = 1; c <= TMO; c++) begin
            check_val("rsp_req_low", 64'(bus_req_valid), 64'd0);
            check_val("rsp_wb_idle", 64'(wb_valid), 64'd0);
            bus_rsp_valid = (c == rsp_wait + 1);
            bus_rsp_err = rsp_err; bus_rsp_data = rsp_data;
            @(posedge clk); #1;
            if (c == rsp_wait + 1) break;
         end
         bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
         lane = rsp_data >> (8 * off);
         ext  = lane & mask[31:0];
         if (sgn && (((lane >> (8 * nbytes - 1)) & 32'd1) == 32'd1)) ext = ext | ~mask[31:0];
         if (rsp_wait + 1 > TMO) begin
            e_fault = 1'b1; e_data = 32'd0;
         end else begin
            e_fault = rsp_err;
            e_data  = (is_load && !rsp_err) ? ext : 32'd0;
         end
      end

      for (int i = 0; i <= wb_wait; i++) begin
         wb_ready = (i == wb_wait);
         #1;
         check_val("wb_valid", 64'(wb_valid), 64'd1);
         check_val("wb_rd_addr", 64'(wb_rd_addr), 64'(rd));
         check_val("wb_rd_data", 64'(wb_rd_data), 64'(e_data));
         check_val("wb_mem_op", 64'(wb_mem_op), 64'(op));
         check_val("wb_fault", 64'(wb_fault), 64'(e_fault));
         check_val("done_in_ready", 64'(in_ready), 64'(i == wb_wait));
         @(posedge clk); #1;
      end
      wb_ready = 1'b0;
      check_val("wb_drop", 64'(wb_valid), 64'd0);
   endtask

   initial begin
      logic [1:0]  r_op, r_size;
      logic [31:0] r_addr;
      in_valid = 1'b0; in_mem_op = 2'd0; in_size = 2'd0; in_signed = 1'b0;
      in_addr = 32'd0; in_wdata = 32'd0; in_rd_addr = 5'd0; in_rd_data = 32'd0;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = 32'd0; bus_rsp_err = 1'b0;
      wb_ready = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // NONE op, then three back-to-back NONE ops with wb_ready held high.
      run_op(2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd5, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0, 0);
      wb_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_mem_op = 2'd0; in_rd_addr = 5'(k + 7); in_rd_data = 32'h1000 + k;
         #1;
         check_val("b2b_ready", 64'(in_ready), 64'd1);
         @(posedge clk); #1;
         check_val("b2b_valid", 64'(wb_valid), 64'd1);
         check_val("b2b_rd", 64'(wb_rd_addr), 64'(k + 7));
         check_val("b2b_data", 64'(wb_rd_data), 64'(32'h1000 + k));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check_val("b2b_end", 64'(wb_valid), 64'd0);
      wb_ready = 1'b0;

      // Byte loads, signed and unsigned, from the top lane.
      run_op(2'd1, 2'd0, 1'b1, 32'h1003, 32'h0, 5'd3, 32'h0, 0, 0, 1'b0, 32'h8011_2233, 0);
      run_op(2'd1, 2'd0, 1'b0, 32'h1003, 32'h0, 5'd3, 32'h0, 0, 1, 1'b0, 32'h8011_2233, 0);
      // Halfword store with the bus stalling for three cycles.
      run_op(2'd2, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD, 5'd0, 32'h0, 3, 0, 1'b0, 32'h0, 0);
      // Misaligned word and doubleword on a 32-bit bus.
      run_op(2'd1, 2'd2, 1'b0, 32'h3001, 32'h0, 5'd9, 32'h0, 0, 0, 1'b0, 32'h0, 0);
      run_op(2'd2, 2'd3, 1'b0, 32'h3000, 32'h1234, 5'd9, 32'h0, 0, 0, 1'b0, 32'h0, 0);
      // Timeout, response on the last allowed cycle, bus error.
      run_op(2'd1, 2'd2, 1'b0, 32'h4000, 32'h0, 5'd4, 32'h0, 0, TMO, 1'b0, 32'h5555_AAAA, 0);
      run_op(2'd1, 2'd2, 1'b0, 32'h4000, 32'h0, 5'd4, 32'h0, 0, TMO - 1, 1'b0, 32'h5555_AAAA, 0);
      run_op(2'd1, 2'd1, 1'b1, 32'h4002, 32'h0, 5'd4, 32'h0, 1, 0, 1'b1, 32'hF00F_1234, 0);
      // Writeback stalled five cycles.
      run_op(2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd12, 32'hCAFE_F00D, 0, 0, 1'b0, 32'h0, 5);

      // Reset asserted with a request pending, then with a response pending.
      in_valid = 1'b1; in_mem_op = 2'd2; in_size = 2'd2; in_addr = 32'h5004;
      in_wdata = 32'h7777_8888; in_rd_addr = 5'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_val("rst_req_pre", 64'(bus_req_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("rst_in_req");
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1; in_mem_op = 2'd1; in_size = 2'd2; in_addr = 32'h6000; in_rd_addr = 5'd2;
      @(posedge clk); #1;
      in_valid = 1'b0; bus_req_ready = 1'b1;
      @(posedge clk); #1;
      bus_req_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("rst_in_rsp");
      bus_rsp_valid = 1'b1; bus_rsp_data = 32'h1111_2222;
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      bus_rsp_valid = 1'b0;
      check_val("rsp_after_rst_ignored", 64'(wb_valid), 64'd0);

      // Randomized ops against the model.
      for (int n = 0; n < 150; n++) begin
         r_op   = 2'($urandom % 4);
         r_size = 2'($urandom % 4);
         r_addr = $urandom;
         if ($urandom % 4 != 0) r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
         run_op(r_op, r_size, 1'($urandom % 2), r_addr, $urandom, 5'($urandom),
                $urandom, int'($urandom % 4), int'($urandom % 6),
                ($urandom % 8) == 0, $urandom, int'($urandom % 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
